// File: rtl/easyaxi_rd_arb.sv
// easyaxi_rd_arb: round-robin arbiter that funnels MST_NUM AXI read masters
// onto one slave read port, with a single burst in flight at any time.
// Field widths come from the shared AXI width macros. Defaults are provided
// here only for the case where no project-wide header has defined them.
`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_SIZE_W
`define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
`define AXI_BURST_W 2
`endif
`ifndef AXI_USER_W
`define AXI_USER_W 4
`endif
`ifndef AXI_DATA_W
`define AXI_DATA_W 32
`endif
`ifndef AXI_RESP_W
`define AXI_RESP_W 2
`endif

module easyaxi_rd_arb #(
    parameter int MST_NUM = 2,
    parameter int GNT_W   = $clog2(MST_NUM)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    // master-side AR
    input  logic [MST_NUM-1:0]                 axi_mst_arvalid,
    output logic [MST_NUM-1:0]                 axi_mst_arready,
    input  logic [MST_NUM*`AXI_ID_W-1:0]       axi_mst_arid,
    input  logic [MST_NUM*`AXI_ADDR_W-1:0]     axi_mst_araddr,
    input  logic [MST_NUM*`AXI_LEN_W-1:0]      axi_mst_arlen,
    input  logic [MST_NUM*`AXI_SIZE_W-1:0]     axi_mst_arsize,
    input  logic [MST_NUM*`AXI_BURST_W-1:0]    axi_mst_arburst,
    input  logic [MST_NUM*`AXI_USER_W-1:0]     axi_mst_aruser,
    // master-side R
    output logic [MST_NUM-1:0]                 axi_mst_rvalid,
    input  logic [MST_NUM-1:0]                 axi_mst_rready,
    output logic [`AXI_ID_W-1:0]               axi_mst_rid,
    output logic [`AXI_DATA_W-1:0]             axi_mst_rdata,
    output logic [`AXI_RESP_W-1:0]             axi_mst_rresp,
    output logic                               axi_mst_rlast,
    output logic [`AXI_USER_W-1:0]             axi_mst_ruser,
    // slave-side AR
    output logic                               axi_slv_arvalid,
    input  logic                               axi_slv_arready,
    output logic [`AXI_ID_W-1:0]               axi_slv_arid,
    output logic [`AXI_ADDR_W-1:0]             axi_slv_araddr,
    output logic [`AXI_LEN_W-1:0]              axi_slv_arlen,
    output logic [`AXI_SIZE_W-1:0]             axi_slv_arsize,
    output logic [`AXI_BURST_W-1:0]            axi_slv_arburst,
    output logic [`AXI_USER_W-1:0]             axi_slv_aruser,
    // slave-side R
    input  logic                               axi_slv_rvalid,
    output logic                               axi_slv_rready,
    input  logic [`AXI_ID_W-1:0]               axi_slv_rid,
    input  logic [`AXI_DATA_W-1:0]             axi_slv_rdata,
    input  logic [`AXI_RESP_W-1:0]             axi_slv_rresp,
    input  logic                               axi_slv_rlast,
    input  logic [`AXI_USER_W-1:0]             axi_slv_ruser,
    // status
    output logic                               arb_busy,
    output logic [GNT_W-1:0]                   arb_gnt_idx
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t           state, state_nxt;
    logic [GNT_W-1:0] gnt, gnt_nxt;
    logic [GNT_W-1:0] rr_ptr, rr_ptr_nxt;
    logic [GNT_W-1:0] pick;
    logic             found;
    int               idx;

    // round-robin search: first requesting master at or above rr_ptr, wrapping
    always_comb begin
        pick  = rr_ptr;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < MST_NUM; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= MST_NUM) idx = idx - MST_NUM;
            if (!found && axi_mst_arvalid[idx]) begin
                pick  = GNT_W'(idx);
                found = 1'b1;
            end
        end
    end

    // state, grant and round-robin pointer registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            gnt    <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_nxt;
            gnt    <= gnt_nxt;
            rr_ptr <= rr_ptr_nxt;
        end
    end

    // next-state logic and per-state handshake routing
    always_comb begin
        state_nxt       = state;
        gnt_nxt         = gnt;
        rr_ptr_nxt      = rr_ptr;
        axi_mst_arready = '0;
        axi_mst_rvalid  = '0;
        axi_slv_arvalid = 1'b0;
        axi_slv_rready  = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    gnt_nxt   = pick;
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                axi_slv_arvalid      = axi_mst_arvalid[gnt];
                axi_mst_arready[gnt] = axi_slv_arready;
                if (axi_mst_arvalid[gnt] && axi_slv_arready) state_nxt = DATA;
            end
            DATA: begin
                axi_mst_rvalid[gnt] = axi_slv_rvalid;
                axi_slv_rready      = axi_mst_rready[gnt];
                if (axi_slv_rvalid && axi_mst_rready[gnt] && axi_slv_rlast) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = (int'(gnt) == MST_NUM - 1) ? '0 : gnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // AR payload mux: the granted master's slice goes to the slave
    always_comb begin
        axi_slv_arid    = axi_mst_arid[0 +: `AXI_ID_W];
        axi_slv_araddr  = axi_mst_araddr[0 +: `AXI_ADDR_W];
        axi_slv_arlen   = axi_mst_arlen[0 +: `AXI_LEN_W];
        axi_slv_arsize  = axi_mst_arsize[0 +: `AXI_SIZE_W];
        axi_slv_arburst = axi_mst_arburst[0 +: `AXI_BURST_W];
        axi_slv_aruser  = axi_mst_aruser[0 +: `AXI_USER_W];
        for (int i = 1; i < MST_NUM; i++) begin
            if (GNT_W'(i) == gnt) begin
                axi_slv_arid    = axi_mst_arid[i*`AXI_ID_W +: `AXI_ID_W];
                axi_slv_araddr  = axi_mst_araddr[i*`AXI_ADDR_W +: `AXI_ADDR_W];
                axi_slv_arlen   = axi_mst_arlen[i*`AXI_LEN_W +: `AXI_LEN_W];
                axi_slv_arsize  = axi_mst_arsize[i*`AXI_SIZE_W +: `AXI_SIZE_W];
                axi_slv_arburst = axi_mst_arburst[i*`AXI_BURST_W +: `AXI_BURST_W];
                axi_slv_aruser  = axi_mst_aruser[i*`AXI_USER_W +: `AXI_USER_W];
            end
        end
    end

    // R payload is broadcast; only the granted master sees rvalid
    assign axi_mst_rid   = axi_slv_rid;
    assign axi_mst_rdata = axi_slv_rdata;
    assign axi_mst_rresp = axi_slv_rresp;
    assign axi_mst_rlast = axi_slv_rlast;
    assign axi_mst_ruser = axi_slv_ruser;

    assign arb_busy    = (state != IDLE);
    assign arb_gnt_idx = gnt;

endmodule

// File: tb/tb_easyaxi_rd_arb.sv
// Directed bench for easyaxi_rd_arb: a 2-master and a 4-master instance share
// clock, reset and slave-side inputs; each scenario task checks inline.
`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_SIZE_W
`define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
`define AXI_BURST_W 2
`endif
`ifndef AXI_USER_W
`define AXI_USER_W 4
`endif
`ifndef AXI_DATA_W
`define AXI_DATA_W 32
`endif
`ifndef AXI_RESP_W
`define AXI_RESP_W 2
`endif

module tb_easyaxi_rd_arb;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    // shared slave-side inputs
    logic                    s_arready = 1'b0;
    logic                    s_rvalid = 1'b0;
    logic [`AXI_ID_W-1:0]    s_rid = '0;
    logic [`AXI_DATA_W-1:0]  s_rdata = '0;
    logic [`AXI_RESP_W-1:0]  s_rresp = '0;
    logic                    s_rlast = 1'b0;
    logic [`AXI_USER_W-1:0]  s_ruser = '0;

    // 2-master instance
    logic [1:0]                m2_arvalid = '0, m2_rready = '0;
    logic [2*`AXI_ID_W-1:0]    m2_arid = '0;
    logic [2*`AXI_ADDR_W-1:0]  m2_araddr = '0;
    logic [2*`AXI_LEN_W-1:0]   m2_arlen = '0;
    logic [2*`AXI_SIZE_W-1:0]  m2_arsize = '0;
    logic [2*`AXI_BURST_W-1:0] m2_arburst = '0;
    logic [2*`AXI_USER_W-1:0]  m2_aruser = '0;
    logic [1:0]                m2_arready, m2_rvalid;
    logic [`AXI_ID_W-1:0]      m2_rid, s2_arid;
    logic [`AXI_DATA_W-1:0]    m2_rdata;
    logic [`AXI_RESP_W-1:0]    m2_rresp;
    logic                      m2_rlast, s2_arvalid, s2_rready, busy2;
    logic [`AXI_USER_W-1:0]    m2_ruser, s2_aruser;
    logic [`AXI_ADDR_W-1:0]    s2_araddr;
    logic [`AXI_LEN_W-1:0]     s2_arlen;
    logic [`AXI_SIZE_W-1:0]    s2_arsize;
    logic [`AXI_BURST_W-1:0]   s2_arburst;
    logic [0:0]                gnt2;

    // 4-master instance
    logic [3:0]                m4_arvalid = '0, m4_rready = '0;
    logic [4*`AXI_ID_W-1:0]    m4_arid = '0;
    logic [4*`AXI_ADDR_W-1:0]  m4_araddr = '0;
    logic [4*`AXI_LEN_W-1:0]   m4_arlen = '0;
    logic [4*`AXI_SIZE_W-1:0]  m4_arsize = '0;
    logic [4*`AXI_BURST_W-1:0] m4_arburst = '0;
    logic [4*`AXI_USER_W-1:0]  m4_aruser = '0;
    logic [3:0]                m4_arready, m4_rvalid;
    logic [`AXI_ID_W-1:0]      m4_rid, s4_arid;
    logic [`AXI_DATA_W-1:0]    m4_rdata;
    logic [`AXI_RESP_W-1:0]    m4_rresp;
    logic                      m4_rlast, s4_arvalid, s4_rready, busy4;
    logic [`AXI_USER_W-1:0]    m4_ruser, s4_aruser;
    logic [`AXI_ADDR_W-1:0]    s4_araddr;
    logic [`AXI_LEN_W-1:0]     s4_arlen;
    logic [`AXI_SIZE_W-1:0]    s4_arsize;
    logic [`AXI_BURST_W-1:0]   s4_arburst;
    logic [1:0]                gnt4;

    easyaxi_rd_arb #(.MST_NUM(2)) u2 (
        .clk(clk), .rst_n(rst_n),
        .axi_mst_arvalid(m2_arvalid), .axi_mst_arready(m2_arready),
        .axi_mst_arid(m2_arid), .axi_mst_araddr(m2_araddr), .axi_mst_arlen(m2_arlen),
        .axi_mst_arsize(m2_arsize), .axi_mst_arburst(m2_arburst), .axi_mst_aruser(m2_aruser),
        .axi_mst_rvalid(m2_rvalid), .axi_mst_rready(m2_rready),
        .axi_mst_rid(m2_rid), .axi_mst_rdata(m2_rdata), .axi_mst_rresp(m2_rresp),
        .axi_mst_rlast(m2_rlast), .axi_mst_ruser(m2_ruser),
        .axi_slv_arvalid(s2_arvalid), .axi_slv_arready(s_arready),
        .axi_slv_arid(s2_arid), .axi_slv_araddr(s2_araddr), .axi_slv_arlen(s2_arlen),
        .axi_slv_arsize(s2_arsize), .axi_slv_arburst(s2_arburst), .axi_slv_aruser(s2_aruser),
        .axi_slv_rvalid(s_rvalid), .axi_slv_rready(s2_rready),
        .axi_slv_rid(s_rid), .axi_slv_rdata(s_rdata), .axi_slv_rresp(s_rresp),
        .axi_slv_rlast(s_rlast), .axi_slv_ruser(s_ruser),
        .arb_busy(busy2), .arb_gnt_idx(gnt2)
    );

    easyaxi_rd_arb #(.MST_NUM(4)) u4 (
        .clk(clk), .rst_n(rst_n),
        .axi_mst_arvalid(m4_arvalid), .axi_mst_arready(m4_arready),
        .axi_mst_arid(m4_arid), .axi_mst_araddr(m4_araddr), .axi_mst_arlen(m4_arlen),
        .axi_mst_arsize(m4_arsize), .axi_mst_arburst(m4_arburst), .axi_mst_aruser(m4_aruser),
        .axi_mst_rvalid(m4_rvalid), .axi_mst_rready(m4_rready),
        .axi_mst_rid(m4_rid), .axi_mst_rdata(m4_rdata), .axi_mst_rresp(m4_rresp),
        .axi_mst_rlast(m4_rlast), .axi_mst_ruser(m4_ruser),
        .axi_slv_arvalid(s4_arvalid), .axi_slv_arready(s_arready),
        .axi_slv_arid(s4_arid), .axi_slv_araddr(s4_araddr), .axi_slv_arlen(s4_arlen),
        .axi_slv_arsize(s4_arsize), .axi_slv_arburst(s4_arburst), .axi_slv_aruser(s4_aruser),
        .axi_slv_rvalid(s_rvalid), .axi_slv_rready(s4_rready),
        .axi_slv_rid(s_rid), .axi_slv_rdata(s_rdata), .axi_slv_rresp(s_rresp),
        .axi_slv_rlast(s_rlast), .axi_slv_ruser(s_ruser),
        .arb_busy(busy4), .arb_gnt_idx(gnt4)
    );

    always #5 clk = ~clk;

    // advance past the next rising edge; inputs are driven 1ns after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m2_arvalid = '0; m2_rready = '0; m4_arvalid = '0; m4_rready = '0;
        s_arready = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        m2_arvalid = 2'b11; s_rvalid = 1'b1; s_arready = 1'b1; m2_rready = 2'b11;
        step(); step();
        checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy2); end
        checks++; if (gnt2 !== 1'b0) begin errors++; $display("FAIL reset_gnt got %0d exp 0", gnt2); end
        checks++; if (m2_arready !== 2'b00) begin errors++; $display("FAIL reset_arready got %b exp 00", m2_arready); end
        checks++; if (s2_arvalid !== 1'b0) begin errors++; $display("FAIL reset_slv_arvalid got %0b exp 0", s2_arvalid); end
        checks++; if (s2_rready !== 1'b0) begin errors++; $display("FAIL reset_slv_rready got %0b exp 0", s2_rready); end
        checks++; if (m2_rvalid !== 2'b00) begin errors++; $display("FAIL reset_rvalid got %b exp 00", m2_rvalid); end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        m2_araddr = {32'h0000_0999, 32'h0000_0100};
        m2_arlen  = {8'd7, 8'd3};
        m2_arid   = {4'd9, 4'd5};
        m2_arvalid = 2'b01; s_arready = 1'b1;
        #1;
        checks++; if (s2_arvalid !== 1'b0) begin errors++; $display("FAIL single_latency got %0b exp 0", s2_arvalid); end
        step();
        checks++; if (busy2 !== 1'b1) begin errors++; $display("FAIL single_busy got %0b exp 1", busy2); end
        checks++; if (s2_arvalid !== 1'b1) begin errors++; $display("FAIL single_slv_arvalid got %0b exp 1", s2_arvalid); end
        checks++; if (s2_araddr !== 32'h100) begin errors++; $display("FAIL single_araddr got %h exp 100", s2_araddr); end
        checks++; if ({s2_arlen, s2_arid} !== {8'd3, 4'd5}) begin errors++; $display("FAIL single_arlen_id got %0d/%0d exp 3/5", s2_arlen, s2_arid); end
        checks++; if (m2_arready !== 2'b01) begin errors++; $display("FAIL single_arready got %b exp 01", m2_arready); end
        step();
        m2_arvalid = 2'b00; m2_rready = 2'b01;
        #1;
        checks++; if ({busy2, s2_arvalid} !== 2'b10) begin errors++; $display("FAIL single_data_entry got %b exp 10", {busy2, s2_arvalid}); end
        for (int b = 0; b < 4; b++) begin
            s_rvalid = 1'b1; s_rdata = 32'hA0 + b; s_rlast = (b == 3); s_rid = 4'd5;
            #1;
            checks++; if ({m2_rvalid, s2_rready} !== 3'b011) begin errors++; $display("FAIL single_beat%0d_hs got %b exp 011", b, {m2_rvalid, s2_rready}); end
            checks++; if ({m2_rdata, m2_rid} !== {32'hA0 + b, 4'd5}) begin errors++; $display("FAIL single_beat%0d_data got %h/%0d exp %h/5", b, m2_rdata, m2_rid, 32'hA0 + b); end
            step();
        end
        s_rvalid = 1'b0; s_rlast = 1'b0;
        #1;
        checks++; if ({busy2, m2_rvalid} !== 3'b000) begin errors++; $display("FAIL single_done got %b exp 000", {busy2, m2_rvalid}); end
        // both requesting: pointer at 1 must favour master 1
        m2_arvalid = 2'b11;
        step();
        checks++; if (gnt2 !== 1'b1) begin errors++; $display("FAIL single_rr_ptr got %0d exp 1", gnt2); end
        step();
        m2_arvalid = 2'b00; m2_rready = 2'b10; s_rvalid = 1'b1; s_rlast = 1'b1;
        step();
        s_rvalid = 1'b0; s_rlast = 1'b0;
    endtask

    task automatic test_both();
        do_reset();
        m2_arvalid = 2'b11; s_arready = 1'b1; m2_rready = 2'b11;
        step();
        checks++; if ({gnt2, m2_arready} !== 3'b001) begin errors++; $display("FAIL both_first got %b exp 001", {gnt2, m2_arready}); end
        step();
        m2_arvalid = 2'b10; s_rvalid = 1'b1; s_rlast = 1'b1;
        step();
        s_rvalid = 1'b0; s_rlast = 1'b0;
        #1;
        checks++; if ({busy2, s2_arvalid} !== 2'b00) begin errors++; $display("FAIL both_idle_gap got %b exp 00", {busy2, s2_arvalid}); end
        step();
        checks++; if ({gnt2, m2_arready, s2_arvalid} !== 4'b1101) begin errors++; $display("FAIL both_second got %b exp 1101", {gnt2, m2_arready, s2_arvalid}); end
        step();
        m2_arvalid = 2'b00; s_rvalid = 1'b1; s_rlast = 1'b1;
        #1;
        checks++; if (m2_rvalid !== 2'b10) begin errors++; $display("FAIL both_rvalid got %b exp 10", m2_rvalid); end
        step();
        s_rvalid = 1'b0; s_rlast = 1'b0;
    endtask

    task automatic test_stall();
        do_reset();
        m2_araddr = {32'h0000_0300, 32'h0000_0200};
        m2_arvalid = 2'b01; s_arready = 1'b0;
        step();
        m2_arvalid = 2'b11;
        #1;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if ({busy2, gnt2, m2_arready, s2_arvalid, s2_araddr} !== {1'b1, 1'b0, 2'b00, 1'b1, 32'h200}) begin
                errors++; $display("FAIL stall_c%0d got busy=%0b gnt=%0d rdy=%b av=%0b addr=%h exp 1/0/00/1/200",
                                   c, busy2, gnt2, m2_arready, s2_arvalid, s2_araddr);
            end
            step();
        end
        s_arready = 1'b1;
        #1;
        checks++; if (m2_arready !== 2'b01) begin errors++; $display("FAIL stall_release got %b exp 01", m2_arready); end
        step();
        m2_arvalid = 2'b00;
        // non-granted master ready while granted master holds off
        s_rvalid = 1'b1; s_rlast = 1'b1; m2_rready = 2'b10;
        #1;
        checks++; if ({m2_rvalid, s2_rready} !== 3'b010) begin errors++; $display("FAIL stall_foreign_rready got %b exp 010", {m2_rvalid, s2_rready}); end
        step();
        checks++; if (busy2 !== 1'b1) begin errors++; $display("FAIL stall_no_consume got %0b exp 1", busy2); end
        m2_rready = 2'b01;
        #1;
        checks++; if (s2_rready !== 1'b1) begin errors++; $display("FAIL stall_own_rready got %0b exp 1", s2_rready); end
        step();
        s_rvalid = 1'b0; s_rlast = 1'b0;
        #1;
        checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL stall_done got %0b exp 0", busy2); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        m2_arvalid = 2'b01; s_arready = 1'b1;
        step(); step();
        m2_arvalid = 2'b00; m2_rready = 2'b01; s_rvalid = 1'b1; s_rlast = 1'b0;
        step(); step();
        rst_n = 1'b0;
        step();
        checks++;
        if ({busy2, gnt2, m2_rvalid, s2_rready, m2_arready, s2_arvalid} !== 7'b0) begin
            errors++; $display("FAIL reset_mid got %b exp 0000000", {busy2, gnt2, m2_rvalid, s2_rready, m2_arready, s2_arvalid});
        end
        rst_n = 1'b1;
        step();
        checks++; if ({busy2, m2_rvalid, s2_rready} !== 4'b0) begin errors++; $display("FAIL reset_mid_after got %b exp 0000", {busy2, m2_rvalid, s2_rready}); end
        s_rvalid = 1'b0;
    endtask

    task automatic test_rr4();
        int exp_g[4] = '{3, 1, 3, 1};
        logic [3:0] exp_v;
        do_reset();
        m4_arvalid = 4'b0010; s_arready = 1'b1; m4_rready = 4'b1111;
        step();
        checks++; if (gnt4 !== 2'd1) begin errors++; $display("FAIL rr4_setup got %0d exp 1", gnt4); end
        step();
        m4_arvalid = 4'b0000; s_rvalid = 1'b1; s_rlast = 1'b1;
        step();
        s_rvalid = 1'b0; s_rlast = 1'b0;
        m4_arvalid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            exp_v = 4'b0001 << exp_g[k];
            step();
            checks++; if (gnt4 !== 2'(exp_g[k])) begin errors++; $display("FAIL rr4_gnt%0d got %0d exp %0d", k, gnt4, exp_g[k]); end
            checks++; if (m4_arready !== exp_v) begin errors++; $display("FAIL rr4_arready%0d got %b exp %b", k, m4_arready, exp_v); end
            step();
            s_rvalid = 1'b1; s_rlast = 1'b1;
            #1;
            checks++; if (m4_rvalid !== exp_v) begin errors++; $display("FAIL rr4_rvalid%0d got %b exp %b", k, m4_rvalid, exp_v); end
            step();
            s_rvalid = 1'b0; s_rlast = 1'b0;
            #1;
            checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL rr4_idle%0d got %0b exp 0", k, busy4); end
        end
        m4_arvalid = 4'b0000;
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_both();
        test_stall();
        test_reset_mid();
        test_rr4();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // runaway guard
    initial begin
        #100000;
        $display("FAIL timeout got no finish exp finish");
        $fatal(1, "timeout");
    end

endmodule
